// File: rtl/ram_responder.sv
// RAM end of the cpu-side memory interface: one outstanding word request,
// LAT busy cycles, then a single ACCESS cycle. Illegal requests flag ERROR at once.
module ram_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] memaddr,
  input  logic [31:0] memstore,
  input  logic        memREN,
  input  logic        memWEN,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'd4;
  localparam logic [7:0]  LAST  = 8'(LAT - 1);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, addr_next;
  logic        wr_reg, wr_next;

  logic [31:0] mem [DEPTH];

  logic          legal;
  logic          hold;
  logic [AW-1:0] word;

  assign legal = (memREN ^ memWEN) && (memaddr[1:0] == 2'b00) && ({1'b0, memaddr} < LIMIT);
  // A waiting transaction survives only while the requester repeats it unchanged
  assign hold  = legal && (memaddr == addr_reg) && (memWEN == wr_reg);
  assign word  = addr_reg[AW+1:2];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wr_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wr_reg    <= wr_next;
    end
  end

  // Write commits on the edge that ends the ACCESS cycle; reset wins over it
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_reg == S_ACC && wr_reg) begin
      mem[word] <= memstore;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wr_next    = wr_reg;
    ramstate   = FREE;
    ramload    = '0;
    case (state_reg)
      S_ACC: begin
        ramstate   = ACCESS;
        if (!wr_reg) ramload = mem[word];
        state_next = S_IDLE;
        cnt_next   = '0;
      end
      default: begin
        if (state_reg == S_WAIT && hold) begin
          ramstate = BUSY;
          if (cnt_reg == LAST) state_next = S_ACC;
          else                 cnt_next   = cnt_reg + 8'd1;
        end else if (!(memREN || memWEN)) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (!legal) begin
          ramstate   = ERROR;
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          // Fresh request, or an aborted one replaced: this cycle is cycle 0
          ramstate   = BUSY;
          addr_next  = memaddr;
          wr_next    = memWEN;
          cnt_next   = 8'd1;
          state_next = (LAT == 1) ? S_ACC : S_WAIT;
        end
      end
    endcase
    if (!nRST) begin
      ramstate = FREE;
      ramload  = '0;
    end
  end

endmodule
